// File: rtl/burst_rd_responder.sv
// burst_rd_responder: accepts a burst read request, issues sequential memory reads and streams the returned words as valid/ready beats.
//   clk, rst                          clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready/req_addr/req_len   burst request handshake, start address, beats minus one
//   mem_en/mem_addr/mem_rdata         memory read strobe, address, data returned one cycle after mem_en
//   rd_valid/rd_ready/rd_data/rd_last beat stream, rd_last marks the final beat of the burst
//   busy                              burst in progress
module burst_rd_responder #(
   parameter int ADDR_WIDTH    = 20,
   parameter int COUNTER_WIDTH = 4,
   parameter int DATA_WIDTH    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [ADDR_WIDTH-1:0]    req_addr,
   input  logic [COUNTER_WIDTH-1:0] req_len,
   output logic                     mem_en,
   output logic [ADDR_WIDTH-1:0]    mem_addr,
   input  logic [DATA_WIDTH-1:0]    mem_rdata,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [DATA_WIDTH-1:0]    rd_data,
   output logic                     rd_last,
   output logic                     busy
);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
   state_t state, state_nxt;
   logic [ADDR_WIDTH-1:0] base;
   logic [COUNTER_WIDTH-1:0] len_q, issue_cnt;
   logic inflight, inflight_last;
   logic [1:0][DATA_WIDTH-1:0] buf_data;
   logic [1:0] buf_last;
   logic wptr, rptr;
   logic [1:0] count;
   logic accept, pop, push, last_issue;
   assign req_ready  = state == IDLE;
   assign busy       = state != IDLE;
   assign accept     = req_valid & req_ready;
   assign rd_valid   = count != 2'd0;
   assign pop        = rd_valid & rd_ready;
   assign push       = inflight;
   assign rd_data    = buf_data[rptr];
   assign rd_last    = rd_valid & buf_last[rptr];
   assign mem_addr   = base + ADDR_WIDTH'(issue_cnt);
   assign last_issue = issue_cnt == len_q;
   // Occupancy plus the read in flight, less this cycle's pop, must leave room so the 2-entry buffer never overflows.
   always_comb begin
      mem_en    = 1'b0;
      state_nxt = state;
      mem_en    = (state == ISSUE) && (({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
      state_nxt = (state == IDLE && accept) ? ISSUE :
                  (state == ISSUE && mem_en && last_issue) ? DRAIN :
                  (state == DRAIN && !inflight && (count == 2'd0 || (count == 2'd1 && pop))) ? IDLE :
                  state;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base          <= '0;
         len_q         <= '0;
         issue_cnt     <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         buf_data      <= '0;
         buf_last      <= '0;
         wptr          <= 1'b0;
         rptr          <= 1'b0;
         count         <= 2'd0;
      end else begin
         if (accept) begin
            base      <= req_addr;
            len_q     <= req_len;
            issue_cnt <= '0;
         end else if (mem_en) begin
            issue_cnt <= issue_cnt + COUNTER_WIDTH'(1);
         end
         inflight      <= mem_en;
         inflight_last <= last_issue;
         if (push) begin
            buf_data[wptr] <= mem_rdata;
            buf_last[wptr] <= inflight_last;
            wptr           <= ~wptr;
         end
         if (pop) rptr <= ~rptr;
         count <= count + 2'(push) - 2'(pop);
      end
   end
endmodule

// File: tb/tb_burst_rd_responder.sv
// tb_burst_rd_responder: directed bursts checked against a queue-based model of expected reads and beats.
module tb_burst_rd_responder;
   localparam int AW = 20, CW = 4, DW = 16;
   logic clk = 1'b0, rst, req_valid, rd_ready;
   logic [AW-1:0] req_addr;
   logic [CW-1:0] req_len;
   logic [DW-1:0] mem_rdata = '0;
   logic req_ready, mem_en, rd_valid, rd_last, busy;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] rd_data;
   int total = 0, bad = 0, cyc = 0;
   always #5 clk = ~clk;
   burst_rd_responder #(.ADDR_WIDTH(AW), .COUNTER_WIDTH(CW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_len(req_len), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last), .busy(busy)
   );
   // Memory returns the low address bits one cycle after a read; garbage otherwise.
   always @(posedge clk) mem_rdata <= mem_en ? mem_addr[15:0] : 16'hDEAD;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask
   logic [AW-1:0] exp_addr_q[$], addr_log[$];
   logic [DW:0] exp_beat_q[$], beat_log[$], prev_beat;
   int addr_cyc[$], beat_cyc[$];
   bit active = 0, prev_stall = 0;
   int outstanding = 0, acc_cnt = 0, acc_edge = 0;
   always @(negedge clk) begin : compare
      logic p;
      logic [AW-1:0] a;
      if (rst) begin
         exp_addr_q.delete();
         exp_beat_q.delete();
         active = 0;
         outstanding = 0;
         prev_stall = 0;
         chk("rst_ctl", 32'({mem_en, rd_valid, rd_last, busy}), 32'd0);
         chk("rst_addr", 32'(mem_addr), 32'd0);
         chk("rst_data", 32'(rd_data), 32'd0);
      end else begin
         p = rd_valid && rd_ready;
         chk("req_ready", 32'(req_ready), 32'(!active));
         chk("busy", 32'(busy), 32'(active));
         if (mem_en) begin
            if (exp_addr_q.size() == 0) chk("spurious_mem_en", 32'd1, 32'd0);
            else chk("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
            addr_log.push_back(mem_addr);
            addr_cyc.push_back(cyc);
         end
         if (prev_stall) chk("stall_hold", 32'({rd_valid, rd_last, rd_data}), 32'({1'b1, prev_beat}));
         if (rd_valid) begin
            if (exp_beat_q.size() == 0) chk("spurious_beat", 32'd1, 32'd0);
            else chk("beat", 32'({rd_last, rd_data}), 32'(exp_beat_q[0]));
         end
         if (p && exp_beat_q.size() != 0) begin
            prev_beat = exp_beat_q.pop_front();
            if (prev_beat[DW]) active = 0;
            beat_log.push_back({rd_last, rd_data});
            beat_cyc.push_back(cyc);
         end
         chk("outstanding", 32'(outstanding + int'(mem_en) - int'(p) <= 2), 32'd1);
         outstanding = outstanding + int'(mem_en) - int'(p);
         prev_stall = rd_valid && !rd_ready;
         prev_beat = {rd_last, rd_data};
         if (req_valid && req_ready) begin
            for (int i = 0; i <= int'(req_len); i++) begin
               a = req_addr + AW'(i);
               exp_addr_q.push_back(a);
               exp_beat_q.push_back({i == int'(req_len), a[15:0]});
            end
            active = 1;
            acc_cnt++;
            acc_edge = cyc + 1;
         end
      end
   end
   int mode = 0, ph = 0;
   initial begin
      rd_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (mode == 1) begin
            rd_ready = (ph % 4 == 0) || (ph % 4 == 3);
            ph++;
         end else rd_ready = 1'b1;
      end
   end
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic clear_logs();
      addr_log.delete();
      addr_cyc.delete();
      beat_log.delete();
      beat_cyc.delete();
   endtask
   task automatic send(input logic [AW-1:0] a, input logic [CW-1:0] l);
      int n = 0;
      req_addr = a;
      req_len = l;
      req_valid = 1'b1;
      @(negedge clk);
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask
   task automatic wait_idle();
      int n = 0;
      while ((active || busy) && n < 300) begin
         step();
         n++;
      end
      chk("idle_timeout", 32'(n < 300), 32'd1);
   endtask
   logic [16:0] t1_beats[4] = '{17'h00010, 17'h00011, 17'h00012, 17'h10013};
   logic [19:0] t2_addrs[4] = '{20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001};
   logic [16:0] t2_beats[4] = '{17'h0FFFE, 17'h0FFFF, 17'h00000, 17'h10001};
   initial begin
      int acc0, n;
      rst = 1'b0;
      req_valid = 1'b0;
      req_addr = '0;
      req_len = '0;
      #2 rst = 1'b1;
      step(3);
      rst = 1'b0;
      step();
      chk("ready_after_rst", 32'(req_ready), 32'd1);
      // basic 4-beat burst, full throughput
      clear_logs();
      send(20'h00010, 4'd3);
      wait_idle();
      chk("t1_naddr", 32'(addr_log.size()), 32'd4);
      for (int i = 0; i < addr_log.size() && i < 4; i++) chk("t1_addr", 32'(addr_log[i]), 32'h10 + 32'(i));
      if (addr_cyc.size() == 4) chk("t1_addr_consec", 32'(addr_cyc[3] - addr_cyc[0]), 32'd3);
      if (addr_cyc.size() > 0) chk("t1_first_mem_en", 32'(addr_cyc[0] - acc_edge), 32'd0);
      chk("t1_nbeat", 32'(beat_log.size()), 32'd4);
      for (int i = 0; i < beat_log.size() && i < 4; i++) chk("t1_beat", 32'(beat_log[i]), 32'(t1_beats[i]));
      if (beat_cyc.size() == 4) chk("t1_beat_consec", 32'(beat_cyc[3] - beat_cyc[0]), 32'd3);
      if (beat_cyc.size() > 0) chk("t1_latency", 32'(beat_cyc[0] - acc_edge), 32'd2);
      chk("t1_ready", 32'(req_ready), 32'd1);
      // address wrap
      clear_logs();
      send(20'hFFFFE, 4'd3);
      wait_idle();
      chk("t2_naddr", 32'(addr_log.size()), 32'd4);
      for (int i = 0; i < addr_log.size() && i < 4; i++) chk("t2_addr", 32'(addr_log[i]), 32'(t2_addrs[i]));
      chk("t2_nbeat", 32'(beat_log.size()), 32'd4);
      for (int i = 0; i < beat_log.size() && i < 4; i++) chk("t2_beat", 32'(beat_log[i]), 32'(t2_beats[i]));
      // single beat
      clear_logs();
      send(20'h00ABC, 4'd0);
      wait_idle();
      chk("t3_naddr", 32'(addr_log.size()), 32'd1);
      chk("t3_nbeat", 32'(beat_log.size()), 32'd1);
      if (beat_log.size() > 0) chk("t3_beat", 32'(beat_log[0]), 32'h10ABC);
      if (beat_cyc.size() > 0) chk("t3_latency", 32'(beat_cyc[0] - acc_edge), 32'd2);
      // 16 beats under backpressure
      clear_logs();
      mode = 1;
      send(20'h00100, 4'd15);
      wait_idle();
      mode = 0;
      chk("t4_nbeat", 32'(beat_log.size()), 32'd16);
      for (int i = 0; i < beat_log.size() && i < 16; i++)
         chk("t4_beat", 32'(beat_log[i]), 32'({i == 15, 16'h0100 + 16'(i)}));
      // requests while busy
      clear_logs();
      acc0 = acc_cnt;
      send(20'h00300, 4'd3);
      step();
      req_addr = 20'h00777;
      req_len = 4'd0;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      chk("t5_pulse_ignored", 32'(acc_cnt - acc0), 32'd1);
      send(20'h00400, 4'd1);
      wait_idle();
      chk("t5_accepts", 32'(acc_cnt - acc0), 32'd2);
      chk("t5_naddr", 32'(addr_log.size()), 32'd6);
      if (addr_log.size() == 6) chk("t5_addr4", 32'(addr_log[4]), 32'h400);
      if (addr_log.size() == 6) chk("t5_addr5", 32'(addr_log[5]), 32'h401);
      chk("t5_nbeat", 32'(beat_log.size()), 32'd6);
      // reset mid-burst
      clear_logs();
      send(20'h00200, 4'd7);
      n = 0;
      while (beat_log.size() < 2 && n < 50) begin
         step();
         n++;
      end
      chk("t6_two_beats", 32'(beat_log.size()), 32'd2);
      rst = 1'b1;
      #1;
      chk("t6_rst_ctl", 32'({mem_en, rd_valid, rd_last, busy}), 32'd0);
      chk("t6_rst_addr", 32'(mem_addr), 32'd0);
      chk("t6_rst_data", 32'(rd_data), 32'd0);
      step();
      rst = 1'b0;
      clear_logs();
      step(5);
      chk("t6_quiet", 32'(beat_log.size() + addr_log.size()), 32'd0);
      chk("t6_ready", 32'(req_ready), 32'd1);
      send(20'h00250, 4'd2);
      wait_idle();
      chk("t6_nbeat", 32'(beat_log.size()), 32'd3);
      for (int i = 0; i < beat_log.size() && i < 3; i++)
         chk("t6_beat", 32'(beat_log[i]), 32'({i == 2, 16'h0250 + 16'(i)}));
      chk("leftover_beats", 32'(exp_beat_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
